ex_div_ctrl: RTL and testbench

EX-stage controller sitting directly upstream of the iterative divider and downstream of decode.
- Accepts RV32M DIV/DIVU/REM/REMU from EX and drives the divider's start/operand handshake.
- Holds the pipeline while a divide is in flight, then issues a one-cycle register write-back.
- Keeps a one-entry last-result cache, so a repeated identical divide completes without restarting the divider.

---
 rtl/ex_div_ctrl_pkg.sv | 24 ++
 rtl/ex_div_ctrl_cache.sv | 64 ++++++
 rtl/ex_div_ctrl.sv | 156 +++++++++++++++
 tb/tb_ex_div_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_div_ctrl_pkg.sv
// Shared definitions for the EX-stage divide controller: funct3 codes,
// bus widths and the controller state encoding.
package ex_div_ctrl_pkg;

   localparam int unsigned RegBusW     = 32;
   localparam int unsigned RegAddrBusW = 5;
   localparam int unsigned Funct3W     = 3;

   localparam logic [RegBusW-1:0]     ZeroWord = '0;
   localparam logic [RegAddrBusW-1:0] ZeroAddr = '0;

   localparam logic [Funct3W-1:0] INST_DIV  = 3'b100;
   localparam logic [Funct3W-1:0] INST_DIVU = 3'b101;
   localparam logic [Funct3W-1:0] INST_REM  = 3'b110;
   localparam logic [Funct3W-1:0] INST_REMU = 3'b111;

   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_BUSY  = 4'b0010,
      S_DONE  = 4'b0100,
      S_DRAIN = 4'b1000
   } div_state_e;

endpackage

// File: rtl/ex_div_ctrl_cache.sv
// One-entry last-result cache: tag (dividend, divisor, op) plus result,
// with a combinational hit against the current EX operands.
module div_result_cache
   import ex_div_ctrl_pkg::*;
#(
   parameter bit          CACHE_EN = 1'b1,
   parameter int unsigned XLEN     = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [XLEN-1:0]    lookup_a_i,
   input  logic [XLEN-1:0]    lookup_b_i,
   input  logic [Funct3W-1:0] lookup_op_i,
   input  logic               upd_i,
   input  logic [XLEN-1:0]    upd_a_i,
   input  logic [XLEN-1:0]    upd_b_i,
   input  logic [Funct3W-1:0] upd_op_i,
   input  logic [XLEN-1:0]    upd_data_i,
   output logic               hit_o,
   output logic [XLEN-1:0]    data_o
);

   logic               valid_q, valid_d;
   logic [XLEN-1:0]    a_q, a_d;
   logic [XLEN-1:0]    b_q, b_d;
   logic [Funct3W-1:0] op_q, op_d;
   logic [XLEN-1:0]    data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      data_d  = data_q;
      if (upd_i) begin
         valid_d = 1'b1;
         a_d     = upd_a_i;
         b_d     = upd_b_i;
         op_d    = upd_op_i;
         data_d  = upd_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         data_q  <= data_d;
      end
   end

   assign hit_o  = CACHE_EN & valid_q & (lookup_a_i == a_q) &
                   (lookup_b_i == b_q) & (lookup_op_i == op_q);
   assign data_o = data_q;

endmodule

// File: rtl/ex_div_ctrl.sv
// EX-stage divide controller: launches the iterative divider, holds the
// pipeline while it runs, and issues a single-cycle write-back.
module ex_div_ctrl
   import ex_div_ctrl_pkg::*;
#(
   parameter bit          CACHE_EN = 1'b1,
   parameter int unsigned XLEN     = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   inst_valid_i,
   input  logic                   is_div_i,
   input  logic [Funct3W-1:0]     div_op_i,
   input  logic [XLEN-1:0]        rs1_data_i,
   input  logic [XLEN-1:0]        rs2_data_i,
   input  logic [RegAddrBusW-1:0] rd_addr_i,
   input  logic                   flush_i,
   output logic                   div_start_o,
   output logic [XLEN-1:0]        div_dividend_o,
   output logic [XLEN-1:0]        div_divisor_o,
   output logic [Funct3W-1:0]     div_op_o,
   output logic [RegAddrBusW-1:0] div_waddr_o,
   input  logic [XLEN-1:0]        div_result_i,
   input  logic                   div_ready_i,
   input  logic                   div_busy_i,
   output logic                   hold_o,
   output logic                   wb_we_o,
   output logic [RegAddrBusW-1:0] wb_waddr_o,
   output logic [XLEN-1:0]        wb_wdata_o
);

   div_state_e             state_q, state_d;
   logic [XLEN-1:0]        dividend_q, dividend_d;
   logic [XLEN-1:0]        divisor_q, divisor_d;
   logic [Funct3W-1:0]     op_q, op_d;
   logic [RegAddrBusW-1:0] div_waddr_q, div_waddr_d;
   logic [RegAddrBusW-1:0] wb_waddr_q, wb_waddr_d;
   logic [XLEN-1:0]        wb_wdata_q, wb_wdata_d;

   logic                   accept;
   logic                   cache_hit;
   logic                   cache_upd;
   logic [XLEN-1:0]        cache_data;

   div_result_cache #(
      .CACHE_EN (CACHE_EN),
      .XLEN     (XLEN)
   ) u_cache (
      .clk         (clk),
      .rst         (rst),
      .lookup_a_i  (rs1_data_i),
      .lookup_b_i  (rs2_data_i),
      .lookup_op_i (div_op_i),
      .upd_i       (cache_upd),
      .upd_a_i     (dividend_q),
      .upd_b_i     (divisor_q),
      .upd_op_i    (op_q),
      .upd_data_i  (div_result_i),
      .hit_o       (cache_hit),
      .data_o      (cache_data)
   );

   always_comb begin
      state_d     = state_q;
      dividend_d  = dividend_q;
      divisor_d   = divisor_q;
      op_d        = op_q;
      div_waddr_d = div_waddr_q;
      wb_waddr_d  = wb_waddr_q;
      wb_wdata_d  = wb_wdata_q;
      accept      = 1'b0;
      cache_upd   = 1'b0;
      hold_o      = 1'b0;
      div_start_o = 1'b0;
      wb_we_o     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            accept = inst_valid_i & is_div_i & ~flush_i;
            hold_o = accept;
            if (accept) begin
               if (cache_hit) begin
                  wb_waddr_d = rd_addr_i;
                  wb_wdata_d = cache_data;
                  state_d    = S_DONE;
               end else begin
                  dividend_d  = rs1_data_i;
                  divisor_d   = rs2_data_i;
                  op_d        = div_op_i;
                  div_waddr_d = rd_addr_i;
                  state_d     = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            hold_o = 1'b1;
            // start falls in the ready cycle so the idle divider is not relaunched
            div_start_o = ~div_ready_i & ~flush_i;
            if (flush_i) begin
               state_d = S_DRAIN;
            end else if (div_ready_i) begin
               wb_wdata_d = div_result_i;
               wb_waddr_d = div_waddr_q;
               cache_upd  = 1'b1;
               state_d    = S_DONE;
            end
         end
         S_DONE: begin
            wb_we_o = (wb_waddr_q != ZeroAddr);
            state_d = S_IDLE;
         end
         S_DRAIN: begin
            if (!div_busy_i && !div_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // reset is synchronous, so mask the decoded outputs in the reset cycle itself
      if (rst) begin
         hold_o      = 1'b0;
         div_start_o = 1'b0;
         wb_we_o     = 1'b0;
         cache_upd   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         dividend_q  <= '0;
         divisor_q   <= '0;
         op_q        <= '0;
         div_waddr_q <= '0;
         wb_waddr_q  <= '0;
         wb_wdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         dividend_q  <= dividend_d;
         divisor_q   <= divisor_d;
         op_q        <= op_d;
         div_waddr_q <= div_waddr_d;
         wb_waddr_q  <= wb_waddr_d;
         wb_wdata_q  <= wb_wdata_d;
      end
   end

   assign div_dividend_o = dividend_q;
   assign div_divisor_o  = divisor_q;
   assign div_op_o       = op_q;
   assign div_waddr_o    = div_waddr_q;
   assign wb_waddr_o     = wb_waddr_q;
   assign wb_wdata_o     = wb_wdata_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Randomized bench for ex_div_ctrl: two instances (cache on / cache off),
// each driving a behavioural iterative divider, checked against a result model.
module tb_ex_div_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_valid [2];
   logic        is_div;
   logic        flush;
   logic [2:0]  div_op;
   logic [31:0] rs1, rs2;
   logic [4:0]  rd_addr;

   logic        d_start    [2];
   logic [31:0] d_dividend [2];
   logic [31:0] d_divisor  [2];
   logic [2:0]  d_op       [2];
   logic [4:0]  d_waddr    [2];
   logic        hold       [2];
   logic        wb_we      [2];
   logic [4:0]  wb_waddr   [2];
   logic [31:0] wb_wdata   [2];

   logic [31:0] m_res   [2];
   logic        m_ready [2];
   logic        m_busy  [2];
   int          m_cnt   [2];
   int          launches[2];

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      bit          valid;
      logic [31:0] a, b, res;
      logic [2:0]  op;
   } cache_t;
   cache_t rc;

   always #5 clk = ~clk;

   ex_div_ctrl #(.CACHE_EN(1'b1), .XLEN(32)) u_dut (
      .clk(clk), .rst(rst), .inst_valid_i(inst_valid[0]), .is_div_i(is_div),
      .div_op_i(div_op), .rs1_data_i(rs1), .rs2_data_i(rs2), .rd_addr_i(rd_addr),
      .flush_i(flush), .div_start_o(d_start[0]), .div_dividend_o(d_dividend[0]),
      .div_divisor_o(d_divisor[0]), .div_op_o(d_op[0]), .div_waddr_o(d_waddr[0]),
      .div_result_i(m_res[0]), .div_ready_i(m_ready[0]), .div_busy_i(m_busy[0]),
      .hold_o(hold[0]), .wb_we_o(wb_we[0]), .wb_waddr_o(wb_waddr[0]), .wb_wdata_o(wb_wdata[0])
   );

   ex_div_ctrl #(.CACHE_EN(1'b0), .XLEN(32)) u_dut_nc (
      .clk(clk), .rst(rst), .inst_valid_i(inst_valid[1]), .is_div_i(is_div),
      .div_op_i(div_op), .rs1_data_i(rs1), .rs2_data_i(rs2), .rd_addr_i(rd_addr),
      .flush_i(flush), .div_start_o(d_start[1]), .div_dividend_o(d_dividend[1]),
      .div_divisor_o(d_divisor[1]), .div_op_o(d_op[1]), .div_waddr_o(d_waddr[1]),
      .div_result_i(m_res[1]), .div_ready_i(m_ready[1]), .div_busy_i(m_busy[1]),
      .hold_o(hold[1]), .wb_we_o(wb_we[1]), .wb_waddr_o(wb_waddr[1]), .wb_wdata_o(wb_wdata[1])
   );

   // RV32M divide/remainder semantics including divide-by-zero and overflow
   function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         3'b100:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
         3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110:  return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // iterative divider: launches on start while idle, pulses ready when done
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_busy[i]  <= 1'b0;
            m_ready[i] <= 1'b0;
         end else begin
            m_ready[i] <= 1'b0;
            if (!m_busy[i] && d_start[i]) begin
               m_busy[i]   <= 1'b1;
               m_cnt[i]    <= (d_divisor[i] == 0) ? 1 : int'($urandom_range(20, 33));
               m_res[i]    <= ref_div(d_op[i], d_dividend[i], d_divisor[i]);
               launches[i] <= launches[i] + 1;
            end else if (m_busy[i]) begin
               if (m_cnt[i] == 0) begin
                  m_busy[i]  <= 1'b0;
                  m_ready[i] <= 1'b1;
               end else begin
                  m_cnt[i] <= m_cnt[i] - 1;
               end
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      else n_pass++;
   endtask

   task automatic check_idle_outputs(input int s);
      check("rst_hold", 32'(hold[s]), 0);
      check("rst_start", 32'(d_start[s]), 0);
      check("rst_we", 32'(wb_we[s]), 0);
      check("rst_waddr", 32'(wb_waddr[s]), 0);
      check("rst_wdata", wb_wdata[s], 0);
      check("rst_dividend", d_dividend[s], 0);
      check("rst_divisor", d_divisor[s], 0);
      check("rst_dop", 32'(d_op[s]), 0);
      check("rst_dwaddr", 32'(d_waddr[s]), 0);
   endtask

   // present an instruction in an IDLE cycle; returns after the accept edge
   task automatic issue(input int s, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
      @(negedge clk);
      rs1 = a; rs2 = b; div_op = op; rd_addr = rd; is_div = 1'b1; inst_valid[s] = 1'b1;
      #1 check("hold_accept", 32'(hold[s]), 1);
      @(posedge clk);
      #1 inst_valid[s] = 1'b0; is_div = 1'b0;
   endtask

   task automatic do_div(input int s, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, output int lat);
      logic [31:0] exp_res;
      bit          exp_hit, early_we;
      int          l0;
      exp_res  = ref_div(op, a, b);
      exp_hit  = (s == 0) && rc.valid && rc.a == a && rc.b == b && rc.op == op;
      l0       = launches[s];
      early_we = 1'b0;
      lat      = 0;
      issue(s, op, a, b, rd);
      while (lat < 200) begin
         @(negedge clk);
         lat++;
         if (!hold[s]) break;
         if (wb_we[s]) early_we = 1'b1;
      end
      check("timeout", 32'(lat < 200), 1);
      check("we_early", 32'(early_we), 0);
      check("we", 32'(wb_we[s]), 32'(rd != 0));
      check("waddr", 32'(wb_waddr[s]), 32'(rd));
      check("wdata", wb_wdata[s], exp_res);
      check("hit_lat", 32'(lat == 1), 32'(exp_hit));
      check("launches", 32'(launches[s] - l0), exp_hit ? 0 : 1);
      if (s == 0) begin
         rc.valid = 1'b1; rc.a = a; rc.b = b; rc.op = op; rc.res = exp_res;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          lat, n;
      bit          bad_start, bad_hold, bad_we;
      logic [31:0] a, b;
      logic [2:0]  op;
      logic [4:0]  rd;

      rst = 1'b1; flush = 1'b0; is_div = 1'b0; div_op = '0;
      rs1 = '0; rs2 = '0; rd_addr = '0;
      inst_valid[0] = 1'b0; inst_valid[1] = 1'b0;
      launches[0] = 0; launches[1] = 0;
      rc.valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_idle_outputs(0);
      check_idle_outputs(1);

      do_div(0, 3'b100, 32'd100, 32'd7, 5'd5, lat);
      do_div(0, 3'b110, 32'd100, 32'd7, 5'd6, lat);
      do_div(0, 3'b101, 32'h0000_000A, 32'd0, 5'd7, lat);
      check("dbz_lat", 32'(lat <= 5), 1);

      do_div(0, 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd8, lat);
      do_div(0, 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9, lat);
      do_div(1, 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd8, lat);
      do_div(1, 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9, lat);

      // flush on the 10th BUSY cycle
      n = launches[0];
      issue(0, 3'b100, 32'd1000, 32'd3, 5'd10);
      repeat (9) @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      #1 check("flush_start", 32'(d_start[0]), 0);
      @(posedge clk);
      #1 flush = 1'b0;
      bad_start = 1'b0; bad_hold = 1'b0; bad_we = 1'b0; lat = 0;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (d_start[0]) bad_start = 1'b1;
         if (hold[0]) bad_hold = 1'b1;
         if (wb_we[0]) bad_we = 1'b1;
         if (!m_busy[0] && !m_ready[0]) break;
      end
      check("drain_timeout", 32'(lat < 100), 1);
      check("drain_start", 32'(bad_start), 0);
      check("drain_hold", 32'(bad_hold), 0);
      check("drain_we", 32'(bad_we), 0);
      check("drain_launch", 32'(launches[0] - n), 1);
      do_div(0, 3'b100, 32'd9, 32'd3, 5'd11, lat);
      do_div(0, 3'b100, 32'd1000, 32'd3, 5'd10, lat);

      // reset while BUSY
      issue(0, 3'b101, 32'd12345, 32'd11, 5'd13);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1 check("rst_busy_start", 32'(d_start[0]), 0);
      check("rst_busy_hold", 32'(hold[0]), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      rc.valid = 1'b0;
      @(negedge clk);
      check_idle_outputs(0);
      do_div(0, 3'b101, 32'hFFFF_FFFF, 32'd16, 5'd12, lat);

      do_div(0, 3'b100, 32'd50, 32'd5, 5'd0, lat);
      do_div(0, 3'b100, 32'd50, 32'd5, 5'd3, lat);

      a = 32'd1; b = 32'd1; op = 3'b100;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 2) != 0) begin
            op = 3'(4 + $urandom_range(0, 3));
            a  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 500));
            case ($urandom_range(0, 7))
               0:       b = 32'd0;
               1:       begin b = 32'hFFFF_FFFF; a = 32'h8000_0000; end
               2:       b = $urandom;
               default: b = 32'($urandom_range(1, 40));
            endcase
         end
         rd = 5'($urandom_range(0, 31));
         do_div(0, op, a, b, rd, lat);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
